fifo_wr_arbiter: RTL and testbench

Shares the single write port of one FIFO among NUM_REQ producers using round-robin arbitration with a per-grant burst quantum. Each producer presents a valid/ready interface. The arbiter drives the FIFO's wr_en/data_in and obeys its full flag, so no requester can cause a FIFO overflow. It sits between the producer blocks and the FIFO write side. It never touches the read side.

---
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with a per-grant burst quantum and full-flag backpressure (owner keeps grant while stalled).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active,
    output logic [15:0]                   stall_count
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [3:0]      burst_q, burst_d;
    logic [15:0]     stall_q, stall_d;
    logic            found;
    logic [GW-1:0]   nxt, idx;
    logic            xfer;

    // Search starts just past the previous owner, so it gets lowest priority.
    always_comb begin
        found = 1'b0;
        nxt   = grant_q;
        idx   = grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(grant_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        burst_d      = burst_q;
        stall_d      = stall_q;
        xfer         = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = nxt;
                    burst_d = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                xfer               = req_valid[grant_q] && !fifo_full;
                fifo_wr_en         = xfer;
                fifo_data_in       = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                req_ready[grant_q] = xfer;
                if (!req_valid[grant_q]) begin
                    state_d = IDLE;
                end else if (fifo_full) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else if (burst_q == 4'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_REQ - 1);
            burst_q <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            stall_q <= stall_d;
        end
    end

    assign grant_id     = grant_q;
    assign grant_active = (state_q == GRANT);
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: word-level round-robin model checked every cycle,
// plus hand-computed FIFO write sequences and grant orders per scenario.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic [15:0]     stall_count;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .grant_active(grant_active),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int seq [N];
    logic [7:0] wq [$];
    int gq [$];
    logic prev_act = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level model: owner, words moved in this grant, stall total.
    bit m_busy = 0;
    int m_owner = N - 1;
    int m_done = 0;
    int m_stall = 0;

    always @(negedge clk) begin
        logic         e_wr;
        logic [N-1:0] e_rdy;
        if (!rst_n) begin
            m_busy = 0; m_owner = N - 1; m_done = 0; m_stall = 0;
            chk("rst_wr_en", 32'(fifo_wr_en), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_active", 32'(grant_active), 0);
            chk("rst_data", 32'(fifo_data_in), 0);
            chk("rst_gid", 32'(grant_id), N - 1);
            chk("rst_stall", 32'(stall_count), 0);
        end else begin
            e_wr  = m_busy && req_valid[m_owner] && !fifo_full;
            e_rdy = '0;
            if (e_wr) e_rdy[m_owner] = 1'b1;
            chk("m_wr_en", 32'(fifo_wr_en), 32'(e_wr));
            chk("m_ready", 32'(req_ready), 32'(e_rdy));
            chk("m_active", 32'(grant_active), 32'(m_busy));
            chk("m_gid", 32'(grant_id), m_owner);
            chk("m_stall", 32'(stall_count), m_stall);
            if (e_wr) chk("m_data", 32'(fifo_data_in), 32'(req_data[m_owner*DW +: DW]));
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_owner + k) % N]) begin
                        m_owner = (m_owner + k) % N;
                        m_done = 0;
                        m_busy = 1;
                        break;
                    end
                end
            end else if (!req_valid[m_owner]) begin
                m_busy = 0;
            end else if (fifo_full) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_done++;
                if (m_done == BL) m_busy = 0;
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(i*16 + (seq[i] % 16));
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) seq[i] = 0;
        pack();
        wq.delete();
        gq.delete();
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_ready & req_valid;
        if (fifo_wr_en) wq.push_back(fifo_data_in);
        if (grant_active && !prev_act) gq.push_back(int'(grant_id));
        prev_act = grant_active;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
        pack();
    endtask

    task automatic wait_writes(input int n);
        int cyc = 0;
        while (wq.size() < n && cyc < 200) begin
            step();
            cyc++;
        end
        if (wq.size() < n) chk("timeout_writes", 32'(wq.size()), 32'(n));
    endtask

    task automatic chk_burst(input string nm, input int pos, input int r, input int s0, input int cnt);
        for (int k = 0; k < cnt; k++)
            chk($sformatf("%s[%0d]", nm, pos + k), 32'(wq.size() > pos + k ? wq[pos + k] : 8'hxx),
                32'(r*16 + s0 + k));
    endtask

    task automatic chk_grants(input string nm, input int g0, input int g1, input int g2,
                              input int g3, input int g4, input int cnt);
        int e [5];
        e = '{g0, g1, g2, g3, g4};
        chk({nm, "_cnt"}, 32'(gq.size()), 32'(cnt));
        for (int k = 0; k < cnt; k++)
            chk($sformatf("%s[%0d]", nm, k), 32'(gq.size() > k ? gq[k] : -1), 32'(e[k]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr();
        // Reset and quiet period
        step(); step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("idle_wr_en", 32'(fifo_wr_en), 0);
        chk("idle_gid", 32'(grant_id), 3);

        // Requesters 0 and 2 alternate in bursts of four
        clr();
        req_valid = 4'b0101;
        wait_writes(12);
        req_valid = 4'b0000;
        step(); step();
        chk("t2_words", 32'(wq.size()), 12);
        chk_burst("t2_w", 0, 0, 0, 4);
        chk_burst("t2_w", 4, 2, 0, 4);
        chk_burst("t2_w", 8, 0, 4, 4);
        chk_grants("t2_g", 0, 2, 0, 0, 0, 3);

        // All four valid after a fresh reset
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        clr();
        req_valid = 4'b1111;
        wait_writes(20);
        req_valid = 4'b0000;
        step(); step();
        chk("t3_words", 32'(wq.size()), 20);
        for (int r = 0; r < 4; r++) chk_burst("t3_w", r*4, r, 0, 4);
        chk_burst("t3_w", 16, 0, 4, 4);
        chk_grants("t3_g", 0, 1, 2, 3, 0, 5);

        // Owner 1 stalled for five cycles mid-burst
        clr();
        req_valid = 4'b0010;
        wait_writes(2);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_wr_stall", 32'(fifo_wr_en), 0);
            chk("t4_gid_stall", 32'(grant_id), 1);
        end
        fifo_full = 1'b0;
        wait_writes(4);
        req_valid = 4'b0000;
        step(); step();
        chk("t4_stall", 32'(stall_count), 5);
        chk("t4_words", 32'(wq.size()), 4);
        chk_burst("t4_w", 0, 1, 0, 4);
        chk_grants("t4_g", 1, 0, 0, 0, 0, 1);

        // Owner 3 drops valid after two words; grant wraps to 0
        clr();
        req_valid = 4'b1000;
        wait_writes(2);
        req_valid = 4'b0001;
        wait_writes(6);
        req_valid = 4'b0000;
        step(); step();
        chk("t5_words", 32'(wq.size()), 6);
        chk_burst("t5_w", 0, 3, 0, 2);
        chk_burst("t5_w", 2, 0, 0, 4);
        chk_grants("t5_g", 3, 0, 0, 0, 0, 2);

        // Reset pulse during a burst from requester 2
        clr();
        req_valid = 4'b0100;
        wait_writes(1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_wr_en", 32'(fifo_wr_en), 0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_active", 32'(grant_active), 0);
        chk("t6_data", 32'(fifo_data_in), 0);
        chk("t6_stall", 32'(stall_count), 0);
        step(); step();
        rst_n = 1'b1;
        req_valid = 4'b0110;
        wait_writes(3);
        req_valid = 4'b0000;
        step(); step();
        chk("t6_words", 32'(wq.size()), 3);
        chk_burst("t6_w", 0, 2, 0, 1);
        chk_burst("t6_w", 1, 1, 0, 2);
        chk_grants("t6_g", 2, 1, 0, 0, 0, 2);
        chk("t6_stall_end", 32'(stall_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
